// File: rtl/turbo_output_mux.sv
// rtl/turbo_output_mux.sv - turbo encoder output multiplexer: buffers sys/p1/p2 symbols per block,
// then emits them interleaved at rate 1/3 or punctured rate 1/2.
module turbo_output_mux #(
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_rate_sel,
  input  logic          i_sys_valid,
  input  logic [DW-1:0] i_sys_data,
  input  logic [DW-1:0] i_p1_data,
  output logic          o_sys_ready,
  input  logic          i_p2_valid,
  input  logic [DW-1:0] i_p2_data,
  output logic          o_p2_ready,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rate;
  logic [AW:0]   r_sys_cnt;
  logic [AW:0]   r_p2_cnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_phase;
  logic          r_done;

  logic [DW-1:0] r_sys_mem [DEPTH];
  logic [DW-1:0] r_p1_mem  [DEPTH];
  logic [DW-1:0] r_p2_mem  [DEPTH];

  logic          w_sys_acc;
  logic          w_p2_acc;
  logic [AW:0]   w_sys_cnt_nxt;
  logic [AW:0]   w_p2_cnt_nxt;
  logic          w_last_phase;
  logic          w_out_last;
  logic          w_out_acc;
  logic [DW-1:0] w_sel;

  assign w_sys_acc     = (r_state == COLLECT) && i_sys_valid && (r_sys_cnt < FULL);
  assign w_p2_acc      = (r_state == COLLECT) && i_p2_valid && (r_p2_cnt < FULL);
  assign w_sys_cnt_nxt = r_sys_cnt + {{AW{1'b0}}, w_sys_acc};
  assign w_p2_cnt_nxt  = r_p2_cnt + {{AW{1'b0}}, w_p2_acc};
  assign w_last_phase  = r_rate ? (r_phase == 2'd2) : (r_phase == 2'd1);
  assign w_out_last    = (r_state == EMIT) && (r_idx == LAST_IDX) && w_last_phase;
  assign w_out_acc     = (r_state == EMIT) && i_out_ready;

  assign o_sys_ready = (r_state == COLLECT) && (r_sys_cnt < FULL);
  assign o_p2_ready  = (r_state == COLLECT) && (r_p2_cnt < FULL);
  assign o_out_valid = (r_state == EMIT);
  assign o_out_last  = w_out_last;
  assign o_out_data  = (r_state == EMIT) ? w_sel : '0;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

  // Rate 1/2 keeps p1 on even indices and p2 on odd ones.
  always_comb begin
    w_sel = r_sys_mem[r_idx];
    case (r_phase)
      2'd1:    w_sel = (r_rate || !r_idx[0]) ? r_p1_mem[r_idx] : r_p2_mem[r_idx];
      2'd2:    w_sel = r_p2_mem[r_idx];
      default: w_sel = r_sys_mem[r_idx];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = COLLECT;
      COLLECT: if (w_sys_cnt_nxt == FULL && w_p2_cnt_nxt == FULL) w_state_nxt = EMIT;
      EMIT:    if (w_out_acc && w_out_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rate    <= 1'b0;
      r_sys_cnt <= '0;
      r_p2_cnt  <= '0;
      r_idx     <= '0;
      r_phase   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rate    <= i_rate_sel;
            r_sys_cnt <= '0;
            r_p2_cnt  <= '0;
            r_idx     <= '0;
            r_phase   <= '0;
          end
        end
        COLLECT: begin
          r_sys_cnt <= w_sys_cnt_nxt;
          r_p2_cnt  <= w_p2_cnt_nxt;
        end
        EMIT: begin
          if (w_out_acc) begin
            if (w_out_last) r_done <= 1'b1;
            if (w_last_phase) begin
              r_phase <= '0;
              r_idx   <= r_idx + AW'(1);
            end else begin
              r_phase <= r_phase + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Symbol memories hold no reset; each block rewrites every entry before EMIT reads it.
  always_ff @(posedge i_clk) begin
    if (w_sys_acc) begin
      r_sys_mem[r_sys_cnt[AW-1:0]] <= i_sys_data;
      r_p1_mem[r_sys_cnt[AW-1:0]]  <= i_p1_data;
    end
    if (w_p2_acc) r_p2_mem[r_p2_cnt[AW-1:0]] <= i_p2_data;
  end

endmodule

// File: doc/turbo_output_mux.md
TURBO_OUTPUT_MUX -- requirements
Module: turbo_output_mux

Interface
REQ-001 SHALL have parameter DW, default 4, symbol width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, symbols per code block; power of two, at least 4.
REQ-003 SHALL have parameter AW, default 4, equal to log2(DEPTH).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that opens a new block.
REQ-007 rate_sel  in  1  mode: 0 = rate 1/2 (p1/p2 punctured alternately), 1 = rate 1/3 (no puncturing).
REQ-008 sys_valid  in  1  sys_data and p1_data offered together.
REQ-009 sys_data  in  DW  systematic symbol.
REQ-010 p1_data  in  DW  RSC1 parity symbol.
REQ-011 sys_ready  out  1  sys/p1 pair accepted this cycle if sys_valid is high.
REQ-012 p2_valid  in  1  p2_data offered.
REQ-013 p2_data  in  DW  RSC2 (interleaved-branch) parity symbol.
REQ-014 p2_ready  out  1  p2 symbol accepted this cycle if p2_valid is high.
REQ-015 out_valid  out  1  out_data is valid.
REQ-016 out_ready  in  1  downstream accepts the output symbol.
REQ-017 out_data  out  DW  multiplexed coded symbol.
REQ-018 out_last  out  1  marks the final symbol of the block.
REQ-019 busy  out  1  high whenever the state is not IDLE.
REQ-020 done  out  1  one-cycle pulse after the last symbol is accepted.

Function
REQ-021 SHALL implement the FSM states IDLE, COLLECT and EMIT.
REQ-022 In IDLE, start SHALL latch rate_sel, clear all counters and move to COLLECT; start is ignored in all other states.
REQ-023 In COLLECT, sys_ready SHALL equal (sys_cnt < DEPTH).
- On sys_valid && sys_ready: sys_data goes to sys_mem[sys_cnt], p1_data to p1_mem[sys_cnt], and sys_cnt increments.
REQ-024 In COLLECT, p2_ready SHALL equal (p2_cnt < DEPTH).
- On p2_valid && p2_ready: p2_data goes to p2_mem[p2_cnt] and p2_cnt increments.
- The p2 channel is independent of the sys channel; simultaneous writes to both are allowed.
REQ-025 sys_cnt and p2_cnt SHALL be AW+1 bits wide and saturate at DEPTH; writes after that are not accepted.
REQ-026 The FSM SHALL go from COLLECT to EMIT on the clock edge at which sys_cnt == DEPTH and p2_cnt == DEPTH are both true (counts after that edge's updates).
REQ-027 sys_ready and p2_ready SHALL be 0 outside COLLECT.
REQ-028 In EMIT, out_valid SHALL be 1 from the first EMIT cycle; index i runs from 0 to DEPTH-1 and phase k selects the sub-symbol.
REQ-029 In rate 1/3, each index SHALL emit sys_mem[i], then p1_mem[i], then p2_mem[i]; block length is 3*DEPTH.
REQ-030 In rate 1/2, each index SHALL emit sys_mem[i], then p1_mem[i] if i is even or p2_mem[i] if i is odd; block length is 2*DEPTH.
REQ-031 The output SHALL advance only when out_valid && out_ready; while out_ready is 0, out_data and out_last stay stable.
REQ-032 out_last SHALL be 1 only on the final symbol: i = DEPTH-1 with the last phase of the latched rate.
REQ-033 When the out_last symbol is accepted, done SHALL pulse 1 on the next cycle and the FSM SHALL return to IDLE on the same edge.
REQ-034 out_data SHALL be 0 whenever out_valid is 0.
REQ-035 The rate latched at start SHALL govern the whole block; rate_sel changes mid-block have no effect.
REQ-036 Throughput SHALL be one symbol per cycle when out_ready is held at 1, with no bubbles between indices.
REQ-037 A block SHALL carry no state into the next one apart from memory contents; memory contents are always overwritten before they are read.

Reset
REQ-038 Assertion of rst (low) SHALL immediately force the state to IDLE and set to 0: all counters, the latched rate, sys_ready, p2_ready, out_valid, out_data, out_last, busy and done.
REQ-039 Reset mid-block SHALL abandon the block; after release, the first accepted start begins a fresh block.
REQ-040 Memories SHALL not require reset.

Verification
REQ-041 DEPTH=16, DW=4, rate_sel=1; write sys=i, p1=(i+1)&15, p2=15-i; out_ready=1.
- Expected output: 48 symbols in order 0,1,15, 1,2,14, ..., 15,0,0.
- out_last on symbol 48; done one cycle later.
REQ-042 Same block with rate_sel=0.
- Expected output: 32 symbols 0,1, 1,14, 2,3, 3,12, ...
- out_last on symbol 32.
REQ-043 p2 writes delayed 20 cycles after sys finishes, then sent.
- Expected: out_valid stays 0 until the cycle after the 16th p2 write; sys_ready is 0 after 16 sys writes.
REQ-044 out_ready toggled at random during EMIT.
- Expected: the output sequence matches REQ-041; out_data is stable while stalled; no symbol is lost or duplicated.
REQ-045 rst asserted during EMIT at symbol 10, then released, then a new start with a new block.
- Expected: all outputs are 0 while reset is asserted; the new block is emitted complete and correct.
REQ-046 start pulsed during COLLECT and during EMIT, and 17 sys writes offered.
- Expected: the extra start pulses are ignored; the 17th write is not accepted (sys_ready=0); the output matches REQ-041.
